// File: rtl/alu_regfile_datapath_pkg.sv
// Shared widths, ALU opcodes and register reset constants for the datapath slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int NREGS = 4;
  localparam int AW    = 2;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  localparam logic [WIDTH-1:0] RST_R0 = 32'h12345678;
  localparam logic [WIDTH-1:0] RST_R1 = 32'h9ABCDEF0;
  localparam logic [WIDTH-1:0] RST_R2 = 32'h0F0F0F0F;
  localparam logic [WIDTH-1:0] RST_R3 = 32'hFFFF0000;

  // Reset constant for register idx.
  function automatic logic [WIDTH-1:0] reset_value(input logic [AW-1:0] idx);
    case (idx)
      2'd0:    reset_value = RST_R0;
      2'd1:    reset_value = RST_R1;
      2'd2:    reset_value = RST_R2;
      default: reset_value = RST_R3;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile_datapath_if.sv
// Bundles the datapath control/address/data signals; master drives controls, slave is the datapath.
// Latency: n/a (wiring only).
// Backpressure: none; every field is a level, no handshake.
interface alu_regfile_datapath_if;
  import alu_pkg::*;

  logic             wr;          // write enable
  logic             wsel;        // 1 = ALU result, 0 = data3
  logic [AW-1:0]    addr1;       // read port 1 / operand a
  logic [AW-1:0]    addr2;       // read port 2 / operand b
  logic [AW-1:0]    addr3;       // write address
  logic [WIDTH-1:0] data3;       // external write data
  logic [2:0]       alucontrol;  // ALU opcode
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output wr, wsel, addr1, addr2, addr3, data3, alucontrol,
    input  data1, data2, result, zero, carry, overflow
  );

  modport slave (
    input  wr, wsel, addr1, addr2, addr3, data3, alucontrol,
    output data1, data2, result, zero, carry, overflow
  );

endinterface

// File: rtl/alu_regfile_datapath_alu32.sv
// Combinational 32-bit ALU: add/sub/and/or/xor/nor/slt/sltu with zero, carry, overflow flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b operands; alucontrol opcode; result, zero, carry (add carry / sub no-borrow), overflow.
module alu32
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;

  // One adder serves add and sub: sub is a + ~b + 1, so carry-out means no borrow.
  assign w_is_sub = (alucontrol == ALU_SUB);
  assign w_b_eff  = w_is_sub ? ~b : b;
  assign w_sum    = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
  // Signed overflow: operands (as seen by the adder) agree in sign but the sum does not.
  assign w_ovf    = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (alucontrol)
      ALU_ADD, ALU_SUB: begin
        result   = w_sum[WIDTH-1:0];
        carry    = w_sum[WIDTH];
        overflow = w_ovf;
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  result = {{(WIDTH-1){1'b0}}, (a < b)};
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_regfile_datapath.sv
// 4x32 register file (2 async read ports, 1 sync write port) feeding alu32; write data is ALU result or data3.
// Latency: reads/ALU 0 cycles; writes visible right after the writing rising edge.
// Backpressure: none; a write is accepted on every edge with wr=1 and rst released.
// Ports: clk, rst (async active-low, loads reset constants), bus (slave side of alu_regfile_datapath_if).
module alu_regfile_datapath
  import alu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  alu_regfile_datapath_if.slave     bus
);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] w_data1;
  logic [WIDTH-1:0] w_data2;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_wd;
  logic             w_zero;
  logic             w_carry;
  logic             w_overflow;

  // No write bypass: reads always see the registered value.
  assign w_data1 = r_regs[bus.addr1];
  assign w_data2 = r_regs[bus.addr2];

  alu32 u_alu (
    .a          (w_data1),
    .b          (w_data2),
    .alucontrol (bus.alucontrol),
    .result     (w_result),
    .zero       (w_zero),
    .carry      (w_carry),
    .overflow   (w_overflow)
  );

  assign w_wd = bus.wsel ? w_result : bus.data3;

  // Reset dominates: a write edge that coincides with rst low is discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= reset_value(AW'(i));
      end
    end else if (bus.wr) begin
      r_regs[bus.addr3] <= w_wd;
    end
  end

  assign bus.data1    = w_data1;
  assign bus.data2    = w_data2;
  assign bus.result   = w_result;
  assign bus.zero     = w_zero;
  assign bus.carry    = w_carry;
  assign bus.overflow = w_overflow;

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed bench for alu_regfile_datapath with a behavioural register/ALU model checked every negedge.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_regfile_datapath;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } alu_out_t;

  logic clk;
  logic rst;
  int   tests;
  int   failures;
  bit   chk_en;

  logic [31:0] m_regs [4];
  logic [31:0] rst_c  [4];

  alu_regfile_datapath_if bus ();

  alu_regfile_datapath dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model ALU from plain integer arithmetic.
  function automatic alu_out_t model_alu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    alu_out_t o;
    longint   ua;
    longint   ub;
    longint   sa;
    longint   sb;
    longint   t;
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o  = '0;
    case (op)
      3'd0: begin
        t     = ua + ub;
        o.res = t[31:0];
        o.c   = (t >= 64'sd4294967296);
        t     = sa + sb;
        o.v   = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd1: begin
        o.res = a - b;
        o.c   = (ua >= ub);
        t     = sa - sb;
        o.v   = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd2: o.res = a & b;
      3'd3: o.res = a | b;
      3'd4: o.res = a ^ b;
      3'd5: o.res = ~(a | b);
      3'd6: o.res = (sa < sb) ? 32'd1 : 32'd0;
      default: o.res = (ua < ub) ? 32'd1 : 32'd0;
    endcase
    o.z = (o.res == 32'd0);
    return o;
  endfunction

  // Register model: constants while reset is low, otherwise capture the write at each edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] = rst_c[i];
    end else if (bus.wr) begin
      m_regs[bus.addr3] = bus.wsel
        ? model_alu(m_regs[bus.addr1], m_regs[bus.addr2], bus.alucontrol).res
        : bus.data3;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      alu_out_t e;
      e = model_alu(m_regs[bus.addr1], m_regs[bus.addr2], bus.alucontrol);
      chk("cyc_data1",    bus.data1,           m_regs[bus.addr1]);
      chk("cyc_data2",    bus.data2,           m_regs[bus.addr2]);
      chk("cyc_result",   bus.result,          e.res);
      chk("cyc_zero",     {31'h0, bus.zero},     {31'h0, e.z});
      chk("cyc_carry",    {31'h0, bus.carry},    {31'h0, e.c});
      chk("cyc_overflow", {31'h0, bus.overflow}, {31'h0, e.v});
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] a3,
                         input logic [2:0] op, input logic ws, input logic w,
                         input logic [31:0] d3);
    bus.addr1      = a1;
    bus.addr2      = a2;
    bus.addr3      = a3;
    bus.alucontrol = op;
    bus.wsel       = ws;
    bus.wr         = w;
    bus.data3      = d3;
  endtask

  initial begin
    logic [31:0] lit_res [8];
    tests    = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst_c[0] = 32'h12345678;
    rst_c[1] = 32'h9ABCDEF0;
    rst_c[2] = 32'h0F0F0F0F;
    rst_c[3] = 32'hFFFF0000;
    // Hand-computed results for a=9ABCDEF0, b=0F0F0F0F, opcodes 0..7.
    lit_res[0] = 32'hA9CBEDFF;
    lit_res[1] = 32'h8BADCFE1;
    lit_res[2] = 32'h0A0C0E00;
    lit_res[3] = 32'h9FBFDFFF;
    lit_res[4] = 32'h95B3D1FF;
    lit_res[5] = 32'h60402000;
    lit_res[6] = 32'h00000001;
    lit_res[7] = 32'h00000000;
    rst = 1'b1;
    set_ops(2'd0, 2'd0, 2'd0, ALU_ADD, 1'b0, 1'b0, 32'h0);

    // Reset asserted mid-cycle; constants visible without any clock edge.
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.addr1 = 2'(i);
      bus.addr2 = 2'(3 - i);
      #1;
      chk("rst_data1", bus.data1, rst_c[i]);
      chk("rst_data2", bus.data2, rst_c[3 - i]);
    end
    chk_en = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;

    // Logic / compare / arithmetic on reset values a=R1, b=R2.
    for (int op = 0; op < 8; op++) begin
      set_ops(2'd1, 2'd2, 2'd0, 3'(op), 1'b1, 1'b0, 32'h0);
      #1;
      chk("lit_op_result", bus.result, lit_res[op]);
    end
    set_ops(2'd1, 2'd2, 2'd0, ALU_SUB, 1'b1, 1'b0, 32'h0);
    #1;
    chk("lit_sub_carry", {31'h0, bus.carry}, 32'd1);
    chk("lit_sub_ovf",   {31'h0, bus.overflow}, 32'd0);

    // Self-clear R1 <- R1 - R1.
    edge1();
    set_ops(2'd1, 2'd1, 2'd1, ALU_SUB, 1'b1, 1'b1, 32'h0);
    #1;
    chk("selfclr_result", bus.result, 32'h0);
    chk("selfclr_zero",   {31'h0, bus.zero}, 32'd1);
    edge1();
    bus.wr = 1'b0;
    #1;
    chk("selfclr_R1", bus.data1, 32'h0);

    // Immediate R0 <- 1, then R0 <- R1 - R0.
    set_ops(2'd0, 2'd0, 2'd0, ALU_ADD, 1'b0, 1'b1, 32'h1);
    edge1();
    set_ops(2'd1, 2'd0, 2'd0, ALU_SUB, 1'b1, 1'b1, 32'h0);
    #1;
    chk("imm_sub_result", bus.result, 32'hFFFFFFFF);
    chk("imm_sub_carry",  {31'h0, bus.carry}, 32'd0);
    edge1();
    set_ops(2'd0, 2'd0, 2'd0, ALU_ADD, 1'b1, 1'b0, 32'h0);
    #1;
    chk("imm_R0", bus.data1, 32'hFFFFFFFF);

    // R2 <- R1 + R0, R3 <- R0 - R0.
    set_ops(2'd1, 2'd0, 2'd2, ALU_ADD, 1'b1, 1'b1, 32'h0);
    edge1();
    set_ops(2'd0, 2'd0, 2'd3, ALU_SUB, 1'b1, 1'b1, 32'h0);
    #1;
    chk("r3_zero", {31'h0, bus.zero}, 32'd1);
    edge1();
    set_ops(2'd2, 2'd3, 2'd0, ALU_ADD, 1'b1, 1'b0, 32'h0);
    #1;
    chk("add_R2", bus.data1, 32'hFFFFFFFF);
    chk("sub_R3", bus.data2, 32'h0);

    // Signed overflow: 7FFFFFFF + 1.
    set_ops(2'd0, 2'd0, 2'd0, ALU_ADD, 1'b0, 1'b1, 32'h7FFFFFFF);
    edge1();
    set_ops(2'd0, 2'd0, 2'd1, ALU_ADD, 1'b0, 1'b1, 32'h1);
    edge1();
    set_ops(2'd0, 2'd1, 2'd0, ALU_ADD, 1'b1, 1'b0, 32'h0);
    #1;
    chk("ovf_result", bus.result, 32'h80000000);
    chk("ovf_flag",   {31'h0, bus.overflow}, 32'd1);
    chk("ovf_carry",  {31'h0, bus.carry}, 32'd0);
    set_ops(2'd0, 2'd1, 2'd0, ALU_SUB, 1'b1, 1'b0, 32'h0);
    #1;
    chk("sub_7ffffffe", bus.result, 32'h7FFFFFFE);

    // wr=0 across several edges: nothing changes.
    for (int i = 0; i < 4; i++) begin
      set_ops(2'(i), 2'(i), 2'(i), ALU_ADD, 1'(i & 1), 1'b0, 32'hA5A5A5A5);
      edge1();
    end
    bus.addr1 = 2'd0;
    bus.addr2 = 2'd1;
    #1;
    chk("hold_R0", bus.data1, 32'h7FFFFFFF);
    chk("hold_R1", bus.data2, 32'h00000001);

    // Reset asserted on a write edge discards the write; held reset ignores writes.
    set_ops(2'd2, 2'd0, 2'd2, ALU_ADD, 1'b0, 1'b1, 32'hDEADBEEF);
    @(posedge clk);
    rst = 1'b0;
    #1;
    chk("rstwr_R2", bus.data1, 32'h0F0F0F0F);
    edge1();
    chk("rsthold_R2", bus.data1, 32'h0F0F0F0F);
    #2 rst = 1'b1;

    // First edge after release performs the write.
    edge1();
    bus.wr = 1'b0;
    #1;
    chk("post_rst_wr", bus.data1, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      bus.addr1 = 2'(i);
      #1;
      chk("final_sweep", bus.data1, m_regs[i]);
    end
    edge1();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
